uart_receiver: RTL and testbench

Serial UART receiver: the receive end of the team's 16x-oversampled UART link. It synchronises the incoming serial line and detects the start bit. Each bit is sampled at its midpoint on `Rx_sample_ENABLE` ticks, which come from the shared baud controller. The block assembles one byte per frame and reports it with a valid strobe plus framing/parity error flags to the host logic.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_receiver_receive_counter.sv | 23 ++
 rtl/uart_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_receiver.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// UART shared definitions: receive/transmit FSM state encoding and 16x oversampling constants.
// UART_RX_PARITY_EN adds the parity state to the frame.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;
    localparam int unsigned CNT_W      = $clog2(OVERSAMPLE);
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned IDX_W      = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] MID_SAMPLE  = CNT_W'(7);
    localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} uart_state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} uart_state_e;
`endif

    // Parity bit a transmitter would send for this byte (odd=1 selects odd parity).
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_receiver_receive_counter.sv
// Oversample tick counter for the UART receiver: counts Rx_sample_ENABLE ticks, wraps at
// OVERSAMPLE, synchronous clear has priority over enable.
module receive_counter
    import uart_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampled UART receiver: start detect, mid-bit sampling, byte assembly, error flags.
// Define UART_RX_PARITY_EN to receive an 11-bit frame with a parity bit checked against PARITY_ODD.
module uart_receiver
    import uart_pkg::*;
#(
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RxD,
    input  logic                 Rx_EN,
    input  logic                 Rx_sample_ENABLE,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_FERROR,
    output logic                 Rx_PERROR
);

    logic                 rx_meta;
    logic                 rxs;
    uart_state_e          state;
    logic [CNT_W-1:0]     cnt;
    logic [DATA_BITS-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 start_detect;
    logic                 start_exit;
    logic                 cnt_clear;

    // Idle-high synchroniser so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rxs     <= rx_meta;
        end
    end

    always_comb begin
        start_detect = Rx_sample_ENABLE && (state == StIdle) && !rxs;
        start_exit   = Rx_sample_ENABLE && (state == StStart) && (cnt == MID_SAMPLE);
        cnt_clear    = !Rx_EN || start_detect || start_exit;
    end

    receive_counter u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (Rx_sample_ENABLE),
        .count  (cnt)
    );

`ifdef UART_RX_PARITY_EN
    logic perr_q;
    localparam uart_state_e AfterData = StParity;
`else
    localparam uart_state_e AfterData = StStop;
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
    assign Rx_PERROR = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StIdle;
            shift     <= '0;
            bit_idx   <= '0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            Rx_PERROR <= 1'b0;
`endif
        end else begin
            Rx_VALID <= 1'b0;
            // Disable wins over a coincident sample tick; partial frame is dropped.
            if (!Rx_EN) begin
                state <= StIdle;
            end else if (Rx_sample_ENABLE) begin
                unique case (state)
                    StIdle: begin
                        if (!rxs) begin
                            state     <= StStart;
                            Rx_FERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            Rx_PERROR <= 1'b0;
`endif
                        end
                    end
                    StStart: begin
                        if (cnt == MID_SAMPLE) begin
                            if (rxs) begin
                                state <= StIdle;
                            end else begin
                                state   <= StData;
                                bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
                                perr_q  <= 1'b0;
`endif
                            end
                        end
                    end
                    StData: begin
                        if (cnt == LAST_SAMPLE) begin
                            shift   <= {rxs, shift[DATA_BITS-1:1]};
                            bit_idx <= bit_idx + IDX_W'(1);
                            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                                state <= AfterData;
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        if (cnt == LAST_SAMPLE) begin
                            perr_q <= (rxs != parity_bit(shift, PARITY_ODD));
                            state  <= StStop;
                        end
                    end
`endif
                    StStop: begin
                        if (cnt == LAST_SAMPLE) begin
                            Rx_DATA <= shift;
                            if (!rxs) begin
                                Rx_FERROR <= 1'b1;
                            end
`ifdef UART_RX_PARITY_EN
                            if (perr_q) begin
                                Rx_PERROR <= 1'b1;
                            end
                            Rx_VALID <= rxs && !perr_q;
`else
                            Rx_VALID <= rxs;
`endif
                            state <= StIdle;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: even- and odd-parity instances share one serial line
// and are checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_TICKS = 8 + 16 * (8 + PAR) + 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic RxD = 1'b1;
    logic Rx_EN = 1'b1;
    logic sample_en = 1'b0;
    logic [1:0][7:0] rx_data;
    logic [1:0] rx_valid, rx_ferr, rx_perr;

    int tests_run = 0;
    int fails = 0;
    int tick_cnt = 0;
    int vcnt[2] = '{0, 0};
    int last_vtick[2] = '{0, 0};
    logic [7:0] last_vdata[2];

    // Reference model state, per instance (0 = even, 1 = odd parity).
    logic [7:0] m_data[2];
    logic m_ferr[2], m_perr[2], m_ok[2];
    int m_vcnt[2] = '{0, 0};

    always #5 clk = ~clk;

    uart_receiver #(.PARITY_ODD(1'b0)) dut_even (
        .clk(clk), .reset(reset), .RxD(RxD), .Rx_EN(Rx_EN), .Rx_sample_ENABLE(sample_en),
        .Rx_DATA(rx_data[0]), .Rx_VALID(rx_valid[0]), .Rx_FERROR(rx_ferr[0]),
        .Rx_PERROR(rx_perr[0])
    );
    uart_receiver #(.PARITY_ODD(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .RxD(RxD), .Rx_EN(Rx_EN), .Rx_sample_ENABLE(sample_en),
        .Rx_DATA(rx_data[1]), .Rx_VALID(rx_valid[1]), .Rx_FERROR(rx_ferr[1]),
        .Rx_PERROR(rx_perr[1])
    );

    // One-clk tick every 4 clocks.
    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sample_en = 1'b1;
            @(negedge clk);
            sample_en = 1'b0;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (sample_en) tick_cnt++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (rx_valid[k] === 1'b1) begin
                    vcnt[k]++;
                    last_vtick[k] = tick_cnt;
                    last_vdata[k] = rx_data[k];
                end
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            while (!sample_en) @(posedge clk);
        end
        #1;
    endtask

    // Drives one frame 16 ticks per bit; e is the tick just before the start edge.
    // A bad stop bit is held low only through its mid-bit sample so the tail is not a new start.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop_ok,
                              output int e);
        e = tick_cnt;
        RxD = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            RxD = d[i];
            wait_ticks(16);
        end
        if (PAR != 0) begin
            RxD = pbit;
            wait_ticks(16);
        end
        if (stop_ok) begin
            RxD = 1'b1;
            wait_ticks(16);
        end else begin
            RxD = 1'b0;
            wait_ticks(9);
            RxD = 1'b1;
            wait_ticks(7);
        end
    endtask

    function automatic void model_frame(input logic [7:0] d, input logic pbit,
                                        input logic stop_ok);
        for (int k = 0; k < 2; k++) begin
            int ones;
            logic perr;
            ones = $countones(d) + k;
            perr = (PAR != 0) && (pbit != ((ones % 2) == 1));
            m_data[k] = d;
            m_ferr[k] = !stop_ok;
            m_perr[k] = perr;
            m_ok[k]   = stop_ok && !perr;
            if (m_ok[k]) m_vcnt[k]++;
        end
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        RxD = 1'b1;
        Rx_EN = 1'b1;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            m_data[k] = 8'h00;
            m_ferr[k] = 1'b0;
            m_perr[k] = 1'b0;
            tests_run++;
            if (rx_data[k] !== 8'h00) begin
                fails++; $display("FAIL reset_data[%0d]: got %h want 00", k, rx_data[k]);
            end
            tests_run++;
            if ({rx_valid[k], rx_ferr[k], rx_perr[k]} !== 3'b000) begin
                fails++;
                $display("FAIL reset_flags[%0d]: got v/f/p=%b%b%b want 000", k, rx_valid[k],
                         rx_ferr[k], rx_perr[k]);
            end
        end
        reset = 1'b0;
        wait_ticks(3);
    endtask

    task automatic test_frames();
        logic [7:0] d_tab[$];
        logic p_tab[$];
        logic s_tab[$];
        d_tab = '{8'h55, 8'h0F, 8'hC6};
        p_tab = '{1'b0, 1'b1, 1'b0};
        s_tab = '{1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            d_tab.push_back(d);
            p_tab.push_back((^d) ^ 1'($urandom_range(0, 1)));
            s_tab.push_back($urandom_range(0, 3) != 0);
        end
        foreach (d_tab[i]) begin
            int e;
            send_frame(d_tab[i], p_tab[i], s_tab[i], e);
            model_frame(d_tab[i], p_tab[i], s_tab[i]);
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (vcnt[k] !== m_vcnt[k]) begin
                    fails++; $display("FAIL frame%0d_valid_count[%0d]: got %0d want %0d", i, k,
                                      vcnt[k], m_vcnt[k]);
                end
                tests_run++;
                if (rx_data[k] !== m_data[k]) begin
                    fails++; $display("FAIL frame%0d_data[%0d]: got %h want %h", i, k,
                                      rx_data[k], m_data[k]);
                end
                tests_run++;
                if ({rx_ferr[k], rx_perr[k]} !== {m_ferr[k], m_perr[k]}) begin
                    fails++; $display("FAIL frame%0d_flags[%0d]: got f/p=%b%b want %b%b", i, k,
                                      rx_ferr[k], rx_perr[k], m_ferr[k], m_perr[k]);
                end
                if (m_ok[k]) begin
                    tests_run++;
                    if (last_vtick[k] !== e + 1 + FRAME_TICKS || last_vdata[k] !== d_tab[i]) begin
                        fails++;
                        $display("FAIL frame%0d_latency[%0d]: got tick %0d data %h want %0d %h",
                                 i, k, last_vtick[k] - e, last_vdata[k], 1 + FRAME_TICKS, d_tab[i]);
                    end
                end
            end
            wait_ticks($urandom_range(0, 3));
        end
    endtask

    task automatic test_framing_error();
        int e;
        send_frame(8'hA3, ^8'hA3, 1'b0, e);
        model_frame(8'hA3, ^8'hA3, 1'b0);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (rx_ferr[k] !== 1'b1 || rx_data[k] !== 8'hA3 || vcnt[k] !== m_vcnt[k]) begin
                fails++; $display("FAIL ferror_set[%0d]: got f=%b data %h vcnt %0d want 1 a3 %0d",
                                  k, rx_ferr[k], rx_data[k], vcnt[k], m_vcnt[k]);
            end
        end
        fork
            send_frame(8'h96, ^8'h96, 1'b1, e);
            begin
                wait_ticks(4);
                for (int k = 0; k < 2; k++) begin
                    tests_run++;
                    if (rx_ferr[k] !== 1'b0) begin
                        fails++; $display("FAIL ferror_clear_at_start[%0d]: got %b want 0", k,
                                          rx_ferr[k]);
                    end
                end
            end
        join
        model_frame(8'h96, ^8'h96, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (vcnt[k] !== m_vcnt[k] || rx_data[k] !== 8'h96) begin
                fails++; $display("FAIL ferror_recover[%0d]: got vcnt %0d data %h want %0d 96",
                                  k, vcnt[k], rx_data[k], m_vcnt[k]);
            end
        end
    endtask

    task automatic test_glitch();
        int e;
        logic [7:0] d;
        d = 8'($urandom);
        send_frame(d, ^d, 1'b0, e);
        model_frame(d, ^d, 1'b0);
        RxD = 1'b0;
        wait_ticks(4);
        RxD = 1'b1;
        wait_ticks(24);
        for (int k = 0; k < 2; k++) begin
            m_ferr[k] = 1'b0;
            m_perr[k] = 1'b0;
            tests_run++;
            if (vcnt[k] !== m_vcnt[k] || rx_data[k] !== m_data[k]) begin
                fails++; $display("FAIL glitch_output[%0d]: got vcnt %0d data %h want %0d %h",
                                  k, vcnt[k], rx_data[k], m_vcnt[k], m_data[k]);
            end
            tests_run++;
            if ({rx_ferr[k], rx_perr[k]} !== {m_ferr[k], m_perr[k]}) begin
                fails++; $display("FAIL glitch_flags[%0d]: got f/p=%b%b want 00", k, rx_ferr[k],
                                  rx_perr[k]);
            end
        end
    endtask

    task automatic test_enable_drop();
        int e;
        logic [7:0] d;
        d = 8'($urandom) ^ 8'hFF;
        fork
            send_frame(d, ^d, 1'b1, e);
            begin
                wait_ticks(16 + 16 * 3 + 4);
                Rx_EN = 1'b0;
            end
        join
        for (int k = 0; k < 2; k++) begin
            m_ferr[k] = 1'b0;
            m_perr[k] = 1'b0;
            tests_run++;
            if (vcnt[k] !== m_vcnt[k] || rx_data[k] !== m_data[k]) begin
                fails++; $display("FAIL enable_partial[%0d]: got vcnt %0d data %h want %0d %h",
                                  k, vcnt[k], rx_data[k], m_vcnt[k], m_data[k]);
            end
        end
        wait_ticks(3);
        Rx_EN = 1'b1;
        wait_ticks(3);
        send_frame(8'h3C, ^8'h3C, 1'b1, e);
        model_frame(8'h3C, ^8'h3C, 1'b1);
        for (int k = 0; k < 2; k++) begin
            tests_run++;
            if (vcnt[k] !== m_vcnt[k] || rx_data[k] !== 8'h3C) begin
                fails++; $display("FAIL enable_resume[%0d]: got vcnt %0d data %h want %0d 3c",
                                  k, vcnt[k], rx_data[k], m_vcnt[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int e;
        logic [7:0] seq[2];
        seq = '{8'h01, 8'hFE};
        fork
            send_frame(8'h5B, ^8'h5B, 1'b1, e);
            begin
                wait_ticks(50);
                #3;
                reset = 1'b1;
                #1;
                for (int k = 0; k < 2; k++) begin
                    m_data[k] = 8'h00;
                    m_ferr[k] = 1'b0;
                    m_perr[k] = 1'b0;
                    tests_run++;
                    if ({rx_data[k], rx_valid[k], rx_ferr[k], rx_perr[k]} !== 11'h0) begin
                        fails++; $display("FAIL midframe_reset[%0d]: got data %h v/f/p %b%b%b",
                                          k, rx_data[k], rx_valid[k], rx_ferr[k], rx_perr[k]);
                    end
                end
            end
        join
        @(negedge clk);
        reset = 1'b0;
        wait_ticks(2);
        for (int i = 0; i < 2; i++) begin
            send_frame(seq[i], ^seq[i], 1'b1, e);
            model_frame(seq[i], ^seq[i], 1'b1);
            for (int k = 0; k < 2; k++) begin
                tests_run++;
                if (vcnt[k] !== m_vcnt[k] || rx_data[k] !== seq[i]) begin
                    fails++; $display("FAIL b2b%0d[%0d]: got vcnt %0d data %h want %0d %h", i, k,
                                      vcnt[k], rx_data[k], m_vcnt[k], seq[i]);
                end
                tests_run++;
                if (last_vtick[k] !== e + 1 + FRAME_TICKS) begin
                    fails++; $display("FAIL b2b%0d_latency[%0d]: got %0d want %0d", i, k,
                                      last_vtick[k] - e, 1 + FRAME_TICKS);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_framing_error();
        test_glitch();
        test_enable_drop();
        test_back_to_back();
        wait_ticks(4);
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
